// File: rtl/hamming_pkg.sv
// Shared Hamming SEC definitions: default geometry, the output-buffer state
// type and the reference encoder used by both encoder and corrector benches.
package hamming_pkg;

  localparam int H3_N     = 15;
  localparam int H3_K     = 11;
  localparam int H3_M     = H3_N - H3_K;
  localparam int H3_MAX_N = 63;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } h3_buf_state_t;

  // Position p (1-based) lives at bit p-1; parity at powers of two, data elsewhere.
  function automatic logic [H3_MAX_N-1:0] encode_f(input logic [H3_MAX_N-1:0] data,
                                                   input int n);
    logic [H3_MAX_N-1:0] cw;
    logic [5:0]          d;
    logic                p;
    cw = '0;
    d  = 6'd0;
    for (int pos = 1; pos <= H3_MAX_N; pos++) begin
      if ((pos <= n) && ((pos & (pos - 32'sd1)) != 32'sd0)) begin
        cw[6'(pos - 32'sd1)] = data[d];
        d = d + 6'd1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      p = 1'b0;
      for (int pos = 1; pos <= H3_MAX_N; pos++) begin
        if ((pos <= n) && (((pos >> i) & 32'sd1) != 32'sd0)) begin
          p = p ^ cw[6'(pos - 32'sd1)];
        end
      end
      if ((32'sd1 << i) <= n) begin
        cw[6'((32'sd1 << i) - 32'sd1)] = p;
      end
    end
    return cw;
  endfunction

endpackage

// File: rtl/h3_skid_buffer.sv
// Two-entry FIFO output buffer with EMPTY/ONE/FULL occupancy FSM and a
// registered ready that looks at the next state.
module h3_skid_buffer
  import hamming_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         ready,
  output logic [W-1:0] dout,
  output logic         valid
);

  h3_buf_state_t state_r, state_next_s;
  logic [W-1:0]  head_r, tail_r;
  logic          ready_r;

  // Next occupancy from push/pop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BUF_EMPTY: begin
        if (push) state_next_s = BUF_ONE;
        else      state_next_s = BUF_EMPTY;
      end
      BUF_ONE: begin
        if (push && !pop)      state_next_s = BUF_FULL;
        else if (!push && pop) state_next_s = BUF_EMPTY;
        else                   state_next_s = BUF_ONE;
      end
      BUF_FULL: begin
        if (pop) state_next_s = BUF_ONE;
        else     state_next_s = BUF_FULL;
      end
      default: state_next_s = BUF_EMPTY;
    endcase
  end

  // State and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BUF_EMPTY;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s != BUF_FULL);
    end
  end

  // Entry storage; head always holds the oldest word.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (state_r)
        BUF_EMPTY: if (push) head_r <= din;
        BUF_ONE: begin
          if (push && pop) head_r <= din;
          else if (push)   tail_r <= din;
        end
        BUF_FULL: if (pop) head_r <= tail_r;
        default: head_r <= head_r;
      endcase
    end
  end

  assign ready = ready_r;
  assign valid = (state_r != BUF_EMPTY);
  assign dout  = head_r;

endmodule

// File: rtl/h3_encode_stream_n_k.sv
// Streaming Hamming SEC encoder with a 2-entry output buffer and delivered-word
// counter. Define HAMMING_ERR_INJECT_EN to build the single-bit error injector.
module h3_encode_stream_n_k
  import hamming_pkg::*;
#(
  parameter int n = 15,
  parameter int k = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [k-1:0]         data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [n-1:0]         hamming_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 injected_o,
  input  logic                 inject_i,
  input  logic [$clog2(n)-1:0] inject_pos_i,
  output logic                 inject_armed_o,
  output logic [31:0]          words_o
);

  localparam int PW = $clog2(n);

  logic                ready_s;
  logic                accept_s;
  logic                pop_s;
  logic [H3_MAX_N-1:0] enc_wide_s;
  logic [n-1:0]        flip_s;
  logic                inject_hit_s;
  logic [31:0]         words_r;

  assign accept_s   = valid_i && ready_s;
  assign pop_s      = valid_o && ready_i;
  assign enc_wide_s = encode_f(H3_MAX_N'(data_i), n);

  if (n < H3_MAX_N) begin : g_enc_pad
    logic unused_enc_s;
    assign unused_enc_s = ^enc_wide_s[H3_MAX_N-1:n];
  end

`ifdef HAMMING_ERR_INJECT_EN
  localparam logic [PW-1:0] POS_LIM = PW'(n);
  logic          armed_r;
  logic [PW-1:0] pos_r;
  logic          req_s;

  assign req_s = inject_i && (inject_pos_i < POS_LIM);

  // A same-cycle request re-arms for the following word instead of hitting this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r <= 1'b0;
      pos_r   <= '0;
    end else if (req_s) begin
      armed_r <= 1'b1;
      pos_r   <= inject_pos_i;
    end else if (accept_s) begin
      armed_r <= 1'b0;
    end
  end

  assign inject_hit_s   = armed_r && !req_s;
  assign flip_s         = inject_hit_s ? ({{(n-1){1'b0}}, 1'b1} << pos_r) : '0;
  assign inject_armed_o = armed_r;
`else
  logic unused_inject_s;
  assign unused_inject_s = ^{inject_i, inject_pos_i};
  assign inject_hit_s    = 1'b0;
  assign flip_s          = '0;
  assign inject_armed_o  = 1'b0;
`endif

  h3_skid_buffer #(.W(n + 1)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_s),
    .din   ({inject_hit_s, enc_wide_s[n-1:0] ^ flip_s}),
    .pop   (pop_s),
    .ready (ready_s),
    .dout  ({injected_o, hamming_o}),
    .valid (valid_o)
  );

  // Delivered-codeword counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_r <= 32'd0;
    end else if (pop_s) begin
      words_r <= words_r + 32'd1;
    end
  end

  assign ready_o = ready_s;
  assign words_o = words_r;

endmodule

// File: tb/tb_h3_encode_stream_n_k.sv
// Self-checking bench for h3_encode_stream_n_k (n=15, k=11) against a
// queue-based transaction model; follows HAMMING_ERR_INJECT_EN if defined.
module tb_h3_encode_stream_n_k;

`ifdef HAMMING_ERR_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] data_i = 11'd0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [14:0] hamming_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        injected_o;
  logic        inject_i = 1'b0;
  logic [3:0]  inject_pos_i = 4'd0;
  logic        inject_armed_o;
  logic [31:0] words_o;

  h3_encode_stream_n_k #(.n(15), .k(11)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .hamming_o      (hamming_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .injected_o     (injected_o),
    .inject_i       (inject_i),
    .inject_pos_i   (inject_pos_i),
    .inject_armed_o (inject_armed_o),
    .words_o        (words_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        inj;
    logic [3:0]  pos;
    logic [14:0] cw;
  } exp_t;

  exp_t        q[$];
  logic        exp_ready = 1'b0;
  logic        exp_armed = 1'b0;
  logic [3:0]  exp_pos = 4'd0;
  logic [31:0] exp_words = 32'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Codeword from the positional definition: data fills non-power-of-two
  // positions, then each parity makes its covered positions XOR to zero.
  function automatic logic [14:0] model_encode(input logic [10:0] d);
    bit   b[16];
    int   di;
    logic [14:0] r;
    di = 0;
    for (int p = 1; p <= 15; p++) begin
      if (p == 1 || p == 2 || p == 4 || p == 8) b[p] = 1'b0;
      else begin b[p] = d[di]; di++; end
    end
    for (int pp = 1; pp <= 8; pp = pp * 2) begin
      int ones;
      ones = 0;
      for (int p = 1; p <= 15; p++) if ((p & pp) != 0 && b[p]) ones++;
      b[pp] = (ones % 2) == 1;
    end
    for (int p = 1; p <= 15; p++) r[p-1] = b[p];
    return r;
  endfunction

  // Syndrome = XOR of the 1-based indices of all set bits.
  function automatic logic [3:0] syndrome(input logic [14:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int j = 0; j < 15; j++) if (cw[j]) s = s ^ 4'(j + 1);
    return s;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [10:0] d,
                       input logic rdy, input logic inj, input logic [3:0] ipos);
    logic acc, pop, req;
    exp_t e;
    rst = r; valid_i = v; data_i = d; ready_i = rdy; inject_i = inj; inject_pos_i = ipos;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_ready = 1'b0; exp_armed = 1'b0; exp_pos = 4'd0; exp_words = 32'd0;
    end else begin
      acc = v && exp_ready;
      pop = (q.size() != 0) && rdy;
      req = INJ_EN && inj && (ipos < 4'd15);
      if (pop) begin
        void'(q.pop_front());
        exp_words = exp_words + 32'd1;
      end
      if (acc) begin
        e.cw = model_encode(d); e.inj = 1'b0; e.pos = 4'd0;
        if (INJ_EN && exp_armed && !req) begin
          e.cw[exp_pos] = ~e.cw[exp_pos]; e.inj = 1'b1; e.pos = exp_pos;
        end
        q.push_back(e);
      end
      if (req) begin exp_armed = 1'b1; exp_pos = ipos; end
      else if (acc) exp_armed = 1'b0;
      exp_ready = (q.size() != 2);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 11'h155, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if ({ready_o, valid_o, injected_o, inject_armed_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got rdy/vld/inj/arm=%b want 0000",
                        {ready_o, valid_o, injected_o, inject_armed_o});
    end
    n_cmp++;
    if (hamming_o !== 15'h0000 || words_o !== 32'd0) begin
      n_err++; $display("FAIL reset_data: got hamming=%h words=%0d want 0000/0", hamming_o, words_o);
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 11'h000, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b1 || hamming_o !== 15'h0000) begin
      n_err++; $display("FAIL basic_zero: got valid=%b hamming=%h want 1/0000", valid_o, hamming_o);
    end
    drive(1'b0, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b1 || hamming_o !== 15'h7FFF) begin
      n_err++; $display("FAIL basic_ones: got valid=%b hamming=%h want 1/7fff", valid_o, hamming_o);
    end
    drive(1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b0 || words_o !== 32'd2) begin
      n_err++; $display("FAIL basic_count: got valid=%b words=%0d want 0/2", valid_o, words_o);
    end
    drive(1'b0, 1'b1, 11'h001, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hamming_o !== 15'h0007 || injected_o !== 1'b0) begin
      n_err++; $display("FAIL basic_one: got hamming=%h inj=%b want 0007/0", hamming_o, injected_o);
    end
    drive(1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_backpressure();
    logic [10:0] d[5];
    for (int i = 0; i < 5; i++) begin
      d[i] = 11'($urandom);
      drive(1'b0, 1'b1, d[i], 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (ready_o !== (i == 0)) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", i, ready_o, (i == 0));
      end
    end
    n_cmp++;
    if (valid_o !== 1'b1 || hamming_o !== model_encode(d[0])) begin
      n_err++; $display("FAIL bp_hold: got valid=%b hamming=%h want 1/%h", valid_o, hamming_o, model_encode(d[0]));
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b1 || hamming_o !== model_encode(d[1]) || ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_second: got valid=%b hamming=%h ready=%b want 1/%h/1",
                        valid_o, hamming_o, ready_o, model_encode(d[1]));
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b0 || words_o !== exp_words) begin
      n_err++; $display("FAIL bp_drain: got valid=%b words=%0d want 0/%0d", valid_o, words_o, exp_words);
    end
  endtask

  task automatic test_injection();
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 4'd4);
    n_cmp++;
    if (inject_armed_o !== INJ_EN) begin
      n_err++; $display("FAIL inj_arm: got %b want %b", inject_armed_o, INJ_EN);
    end
    drive(1'b0, 1'b1, 11'h000, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hamming_o !== (INJ_EN ? 15'h0010 : 15'h0000) || injected_o !== INJ_EN || inject_armed_o !== 1'b0) begin
      n_err++; $display("FAIL inj_word: got hamming=%h inj=%b armed=%b want %h/%b/0",
                        hamming_o, injected_o, inject_armed_o, (INJ_EN ? 15'h0010 : 15'h0000), INJ_EN);
    end
    n_cmp++;
    if (syndrome(hamming_o) !== (INJ_EN ? 4'd5 : 4'd0)) begin
      n_err++; $display("FAIL inj_syndrome: got %0d want %0d", syndrome(hamming_o), (INJ_EN ? 5 : 0));
    end
    drive(1'b0, 1'b1, 11'h7FF, 1'b1, 1'b1, 4'd2);
    n_cmp++;
    if (hamming_o !== 15'h7FFF || injected_o !== 1'b0 || inject_armed_o !== INJ_EN) begin
      n_err++; $display("FAIL inj_same_cycle: got hamming=%h inj=%b armed=%b want 7fff/0/%b",
                        hamming_o, injected_o, inject_armed_o, INJ_EN);
    end
    drive(1'b0, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hamming_o !== (INJ_EN ? 15'h7FFB : 15'h7FFF) || injected_o !== INJ_EN) begin
      n_err++; $display("FAIL inj_following: got hamming=%h inj=%b want %h/%b",
                        hamming_o, injected_o, (INJ_EN ? 15'h7FFB : 15'h7FFF), INJ_EN);
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_inject_invalid();
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 4'd15);
    n_cmp++;
    if (inject_armed_o !== 1'b0) begin
      n_err++; $display("FAIL inj_bad_pos_arm: got %b want 0", inject_armed_o);
    end
    drive(1'b0, 1'b1, 11'h001, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hamming_o !== 15'h0007 || injected_o !== 1'b0) begin
      n_err++; $display("FAIL inj_bad_pos_word: got hamming=%h inj=%b want 0007/0", hamming_o, injected_o);
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_random();
    logic v, rdy, inj;
    logic [3:0] ipos;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(3) != 0);
      rdy  = ($urandom_range(2) != 0);
      inj  = ($urandom_range(15) == 0) && (!v || !exp_armed);
      ipos = 4'($urandom_range(15));
      drive(1'b0, v, 11'($urandom), rdy, inj, ipos);
      n_cmp++;
      if (ready_o !== exp_ready || valid_o !== (q.size() != 0)) begin
        n_err++; $display("FAIL rnd_hs[%0d]: got ready=%b valid=%b want %b/%b",
                          c, ready_o, valid_o, exp_ready, (q.size() != 0));
      end
      n_cmp++;
      if (inject_armed_o !== exp_armed || words_o !== exp_words) begin
        n_err++; $display("FAIL rnd_state[%0d]: got armed=%b words=%0d want %b/%0d",
                          c, inject_armed_o, words_o, exp_armed, exp_words);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (hamming_o !== q[0].cw || injected_o !== q[0].inj) begin
          n_err++; $display("FAIL rnd_data[%0d]: got hamming=%h inj=%b want %h/%b",
                            c, hamming_o, injected_o, q[0].cw, q[0].inj);
        end
        n_cmp++;
        if (syndrome(hamming_o) !== (q[0].inj ? q[0].pos + 4'd1 : 4'd0)) begin
          n_err++; $display("FAIL rnd_syndrome[%0d]: got %0d want %0d",
                            c, syndrome(hamming_o), (q[0].inj ? q[0].pos + 4'd1 : 4'd0));
        end
      end
    end
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid();
    logic [10:0] d;
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 11'($urandom), 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 11'($urandom), 1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || words_o === 32'd0) begin
      n_err++; $display("FAIL mid_full: got ready=%b valid=%b words=%0d want 0/1/nonzero",
                        ready_o, valid_o, words_o);
    end
    drive(1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (valid_o !== 1'b0 || words_o !== 32'd0 || ready_o !== 1'b0 || inject_armed_o !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got valid=%b words=%0d ready=%b armed=%b want 0/0/0/0",
                        valid_o, words_o, ready_o, inject_armed_o);
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_err++; $display("FAIL mid_release: got ready=%b valid=%b want 1/0", ready_o, valid_o);
    end
    d = 11'($urandom);
    drive(1'b0, 1'b1, d, 1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hamming_o !== model_encode(d) || injected_o !== 1'b0) begin
      n_err++; $display("FAIL mid_clean_word: got hamming=%h inj=%b want %h/0",
                        hamming_o, injected_o, model_encode(d));
    end
    drive(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_injection();
    test_inject_invalid();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
